// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// Holds the state encoding (also exported on the debug state port),
// default parameter values and small width helpers.
package pll_reset_sequencer_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned LOL_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } pll_seq_state_t;

    localparam int unsigned DEF_RST_HOLD_CYCLES     = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 256;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 100000;
    localparam int unsigned DEF_MAX_RETRIES         = 3;
    localparam int unsigned DEF_NUM_DOMAINS         = 6;
    localparam int unsigned DEF_STAGGER_CYCLES      = 4;

    // Depth of the pll_locked synchronizer.
    localparam int unsigned lock_sync_stages = 2;

    // Width of the retry counter; never narrower than one bit.
    function automatic int unsigned retry_width(input int unsigned max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
//   master: sequencer side (drives pll_rst, dom_rst and status; reads restart, pll_locked)
//   slave : system side (drives restart, pll_locked; reads everything else)
interface pll_reset_sequencer_if
    import pll_reset_sequencer_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int unsigned RETRY_W     = retry_width(DEF_MAX_RETRIES)
) ();

    logic                   restart;
    logic                   pll_locked;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] dom_rst;
    logic                   sys_ready;
    logic                   fault;
    logic [RETRY_W-1:0]     retry_cnt;
    logic [LOL_CNT_W-1:0]   lol_cnt;
    logic [STATE_W-1:0]     state;

    modport master (
        input  restart, pll_locked,
        output pll_rst, dom_rst, sys_ready, fault, retry_cnt, lol_cnt, state
    );

    modport slave (
        output restart, pll_locked,
        input  pll_rst, dom_rst, sys_ready, fault, retry_cnt, lol_cnt, state
    );

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// sync_2ff: generic multi-flop bit synchronizer with synchronous active-low reset.
//   clk, rst_n : destination clock and reset
//   d          : asynchronous input bit
//   q          : synchronized output, STAGES clk edges behind d
module sync_2ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; bit 0 is the metastability-catching flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: brings the PLL out of reset, qualifies lock, retries
// failed lock attempts and releases downstream domain resets in staggered
// ascending order. Loss of lock re-asserts every domain reset and relocks.
//   refclk : free-running reference clock (only clock)
//   rst_n  : synchronous active-low reset
//   bus    : master modport carrying restart/pll_locked in and
//            pll_rst/dom_rst/sys_ready/fault/retry_cnt/lol_cnt/state out
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int unsigned NUM_DOMAINS         = DEF_NUM_DOMAINS,
    parameter int unsigned STAGGER_CYCLES      = DEF_STAGGER_CYCLES
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.master bus
);

    localparam int unsigned RETRY_W  = retry_width(MAX_RETRIES);
    localparam int unsigned REL_SPAN = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
    localparam int unsigned CNT_MAX  = max2(max2(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES),
                                            max2(LOCK_TIMEOUT_CYCLES, REL_SPAN));
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REL_LAST     = CNT_W'(REL_SPAN);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    pll_seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [LOL_CNT_W-1:0]   lol_q, lol_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic                   sys_ready_q, sys_ready_d;
    logic                   fault_q, fault_d;
    logic                   lock_s;
    logic                   lol_event;

    // Bring the asynchronous lock indication into the refclk domain.
    sync_2ff #(
        .STAGES    (lock_sync_stages),
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (lock_s)
    );

    // State, shared counter and all output registers.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            retry_q     <= '0;
            lol_q       <= '0;
            pll_rst_q   <= 1'b1;
            dom_rst_q   <= '1;
            sys_ready_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lol_q       <= lol_d;
            pll_rst_q   <= pll_rst_d;
            dom_rst_q   <= dom_rst_d;
            sys_ready_q <= sys_ready_d;
            fault_q     <= fault_d;
        end
    end

    // Next state, counter and next-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        lol_d       = lol_q;
        lol_event   = 1'b0;
        pll_rst_d   = 1'b0;
        dom_rst_d   = '1;
        sys_ready_d = 1'b0;
        fault_d     = 1'b0;

        if (bus.restart) begin
            state_d = ST_RESET;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a coincident timeout.
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = ST_FAULT;
                        end else begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = ST_RESET;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!lock_s) begin
                        lol_event = 1'b1;
                        state_d   = ST_RESET;
                    end else if (cnt_q == REL_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        lol_event = 1'b1;
                        state_d   = ST_RESET;
                    end
                end
                ST_FAULT: ;
                default: state_d = ST_RESET;
            endcase
        end

        if (lol_event && (lol_q != '1)) lol_d = lol_q + LOL_CNT_W'(1);

        // Counter restarts on every state entry (a restart counts as re-entry).
        if (bus.restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q != ST_RUN) && (state_q != ST_FAULT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAULT);
        sys_ready_d = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);

        // In RELEASE the counter is the cycle count since entry; domain i
        // is released once that count reaches i*STAGGER_CYCLES.
        if (state_d == ST_RUN) begin
            dom_rst_d = '0;
        end else if (state_d == ST_RELEASE) begin
            for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                dom_rst_d[i] = 32'(cnt_d) < (i * STAGGER_CYCLES);
            end
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.dom_rst   = dom_rst_q;
    assign bus.sys_ready = sys_ready_q;
    assign bus.fault     = fault_q;
    assign bus.retry_cnt = retry_q;
    assign bus.lol_cnt   = lol_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural phase/elapsed-time model.
module tb_pll_reset_sequencer;

    localparam int H  = 4;
    localparam int LS = 8;
    localparam int TO = 20;
    localparam int MR = 2;
    localparam int ND = 6;
    localparam int SG = 2;

    localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RELEASE = 3, P_RUN = 4, P_FAULT = 5;

    logic refclk;
    logic rst_n;

    pll_reset_sequencer_if #(.NUM_DOMAINS(ND), .RETRY_W(2)) bus ();

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES     (H),
        .LOCK_STABLE_CYCLES  (LS),
        .LOCK_TIMEOUT_CYCLES (TO),
        .MAX_RETRIES         (MR),
        .NUM_DOMAINS         (ND),
        .STAGGER_CYCLES      (SG)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase, cycles elapsed in phase, counters, lock delay line.
    int m_phase = P_RESET;
    int m_t     = 0;
    int m_retry = 0;
    int m_lol   = 0;
    bit m_s1    = 1'b0;
    bit m_s2    = 1'b0;

    // PLL behaviour: lock follows pll_rst low by lock_delay cycles when enabled.
    bit lock_en     = 1'b1;
    int lock_delay  = 0;
    int rst_low_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit exp_pll_rst();
        return (m_phase == P_RESET) || (m_phase == P_FAULT);
    endfunction

    function automatic logic [ND-1:0] exp_dom();
        logic [ND-1:0] d;
        d = '1;
        if (m_phase == P_RUN) d = '0;
        else if (m_phase == P_RELEASE)
            for (int i = 0; i < ND; i++) if (m_t >= i * SG) d[i] = 1'b0;
        return d;
    endfunction

    // One refclk edge of the behavioural model.
    task automatic model_step(input bit rn, input bit rs, input bit pl);
        bit ls;
        int np;
        int elapsed;
        if (!rn) begin
            m_phase = P_RESET; m_t = 0; m_retry = 0; m_lol = 0; m_s1 = 0; m_s2 = 0;
            return;
        end
        ls      = m_s2;
        m_s2    = m_s1;
        m_s1    = pl;
        np      = m_phase;
        elapsed = m_t + 1;
        if (rs) begin
            np = P_RESET;
            m_retry = 0;
        end else begin
            case (m_phase)
                P_RESET:  if (elapsed == H) np = P_WAIT;
                P_WAIT: begin
                    if (ls) np = P_STABLE;
                    else if (elapsed == TO) begin
                        if (m_retry < MR) begin m_retry++; np = P_RESET; end
                        else np = P_FAULT;
                    end
                end
                P_STABLE: begin
                    if (!ls) np = P_WAIT;
                    else if (elapsed == LS) np = P_RELEASE;
                end
                P_RELEASE, P_RUN: begin
                    if (!ls) begin
                        if (m_lol < 255) m_lol++;
                        np = P_RESET;
                    end else if (m_phase == P_RELEASE && m_t == (ND - 1) * SG) begin
                        np = P_RUN;
                        m_retry = 0;
                    end
                end
                default: ;
            endcase
        end
        if (rs || np != m_phase) m_t = 0;
        else m_t = m_t + 1;
        m_phase = np;
    endtask

    task automatic compare_all();
        check("state",     32'(bus.state),     32'(m_phase));
        check("pll_rst",   32'(bus.pll_rst),   32'(exp_pll_rst()));
        check("dom_rst",   32'(bus.dom_rst),   32'(exp_dom()));
        check("sys_ready", 32'(bus.sys_ready), 32'(m_phase == P_RUN));
        check("fault",     32'(bus.fault),     32'(m_phase == P_FAULT));
        check("retry_cnt", 32'(bus.retry_cnt), 32'(m_retry));
        check("lol_cnt",   32'(bus.lol_cnt),   32'(m_lol));
    endtask

    // Drive one cycle: inputs at negedge, model at posedge, compare 1ns later.
    task automatic step(input bit rn, input bit rs, input bit drop);
        bit pl;
        @(negedge refclk);
        pl = lock_en && !drop && !exp_pll_rst() && (rst_low_cnt > lock_delay);
        rst_n          = rn;
        bus.restart    = rs;
        bus.pll_locked = pl;
        @(posedge refclk);
        model_step(rn, rs, pl);
        #1;
        compare_all();
        rst_low_cnt = exp_pll_rst() ? 0 : rst_low_cnt + 1;
    endtask

    task automatic drive_until(input int tp, input int tt, input int budget, input string tag);
        int n;
        n = 0;
        while (!(m_phase == tp && m_t == tt) && n < budget) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        check({tag, "_reach"}, 32'(bus.state), 32'(tp));
    endtask

    initial begin
        int k;
        int lol_before;
        rst_n          = 1'b0;
        bus.restart    = 1'b0;
        bus.pll_locked = 1'b0;

        // Reset, then clean bring-up with lock 5 cycles after pll_rst falls.
        lock_en = 1'b1; lock_delay = 5;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("rst_dom", 32'(bus.dom_rst), 32'(6'h3F));
        drive_until(P_RUN, 0, 200, "bringup");
        check("bringup_dom", 32'(bus.dom_rst), 32'(0));

        // Latency with lock present as soon as pll_rst drops.
        lock_delay = 0;
        repeat (2) step(1'b0, 1'b0, 1'b0);
        k = 0;
        while (!bus.sys_ready && k < 100) begin
            step(1'b1, 1'b0, 1'b0);
            k++;
        end
        check("latency", 32'(k), 32'(H + 3 + LS + (ND - 1) * SG + 1));

        // One-cycle lock glitch after 6 stable cycles.
        step(1'b1, 1'b1, 1'b0);
        drive_until(P_STABLE, 5, 100, "stable6");
        step(1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        check("glitch_state", 32'(bus.state), 32'(P_WAIT));
        check("glitch_dom", 32'(bus.dom_rst), 32'(6'h3F));
        check("glitch_retry", 32'(bus.retry_cnt), 32'(0));
        drive_until(P_RUN, 0, 200, "glitch_run");

        // Lock never arrives: retries then FAULT, restart recovers.
        lock_en = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        drive_until(P_FAULT, 0, 300, "fault");
        repeat (5) step(1'b1, 1'b0, 1'b0);
        check("fault_flag", 32'(bus.fault), 32'(1));
        check("fault_retry", 32'(bus.retry_cnt), 32'(MR));
        check("fault_pll_rst", 32'(bus.pll_rst), 32'(1));
        lock_en = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        check("restart_state", 32'(bus.state), 32'(P_RESET));
        check("restart_retry", 32'(bus.retry_cnt), 32'(0));

        // Loss of lock in RUN: exactly 3 edges to full reassertion.
        drive_until(P_RUN, 0, 200, "lol_run");
        repeat (3) step(1'b1, 1'b0, 1'b0);
        lol_before = m_lol;
        lock_en = 1'b0;
        repeat (2) step(1'b1, 1'b0, 1'b0);
        check("lol_ready_hold", 32'(bus.sys_ready), 32'(1));
        step(1'b1, 1'b0, 1'b0);
        check("lol_dom", 32'(bus.dom_rst), 32'(6'h3F));
        check("lol_ready", 32'(bus.sys_ready), 32'(0));
        check("lol_state", 32'(bus.state), 32'(P_RESET));
        check("lol_cnt1", 32'(bus.lol_cnt), 32'(lol_before + 1));
        lock_en = 1'b1;
        drive_until(P_RUN, 0, 200, "relock");

        // Restart mid-RELEASE with three domains released.
        step(1'b1, 1'b1, 1'b0);
        drive_until(P_RELEASE, 4, 200, "rel3");
        check("rel3_dom", 32'(bus.dom_rst), 32'(6'h38));
        step(1'b1, 1'b1, 1'b0);
        check("rel_restart_dom", 32'(bus.dom_rst), 32'(6'h3F));
        check("rel_restart_pll", 32'(bus.pll_rst), 32'(1));

        // rst_n in RUN clears everything including lol_cnt.
        drive_until(P_RUN, 0, 200, "pre_rst");
        step(1'b0, 1'b0, 1'b0);
        check("run_rst_lol", 32'(bus.lol_cnt), 32'(0));
        check("run_rst_state", 32'(bus.state), 32'(P_RESET));

        // Saturate lol_cnt with repeated losses during RELEASE.
        for (int it = 0; it < 260; it++) begin
            drive_until(P_RELEASE, 0, 200, "sat");
            step(1'b1, 1'b0, 1'b1);
        end
        repeat (4) step(1'b1, 1'b0, 1'b0);
        check("lol_sat", 32'(bus.lol_cnt), 32'(255));

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (exp_pll_rst()) lock_delay = $urandom_range(0, 24);
            if ($urandom_range(0, 299) == 0) lock_en = ~lock_en;
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 29) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
